// File: rtl/mitec2_dram_seq.sv
// mitec2_dram_seq: clocked DRAM sequencer for the Z80 board.
//
// The sequencer decodes up to four 16 KiB DRAM banks from A15:A14. It drives
// registered RAS, CAS and MUX strobes with programmable row-to-column and
// precharge timing, and it holds the CPU with WAIT when an access arrives
// during precharge. RAMA7 carries a refresh row bit from an internal counter,
// so 256-row parts receive a full refresh.
//
// Optional feature macro: MITEC2_CBR_REFRESH_EN
//   When it is undefined, refresh is RAS-only and uses the internal row counter.
//   When it is defined, refresh is CAS-before-RAS, and RAMA7 always follows A7.

module mitec2_dram_seq #(
   parameter int unsigned BANKS     = 2,
   parameter int unsigned BANK_BASE = 2,
   parameter int unsigned T_RCD     = 1,
   parameter int unsigned T_MUX     = 1,
   parameter int unsigned T_RP      = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             MREQ,
   input  logic             RD,
   input  logic             WR,
   input  logic             RFSH,
   input  logic [1:0]       ABANK,
   input  logic             A7,
   output logic [BANKS-1:0] RAS,
   output logic [BANKS-1:0] CAS,
   output logic             MUX,
   output logic             RAMA7,
   output logic             WAIT
);

   typedef enum logic [2:0] {IDLE, ROW, COL, HOLD, REFR, PRE} state_t;

   state_t           state_reg, state_next;
   logic [2:0]       timer_reg, timer_next;
   logic [BANKS-1:0] sel_reg, sel_next;     // one-hot bank latched at RAS fall
   logic [BANKS-1:0] ras_reg, ras_next;
   logic [BANKS-1:0] cas_reg, cas_next;
   logic             mux_reg, mux_next;
   logic             wait_reg, wait_next;
   logic             rama7_reg, rama7_next;
   logic [6:0]       cnt_reg, cnt_next;     // refresh row counter
   logic             t_reg, t_next;         // row bit 7, toggles on counter wrap

   logic [BANKS-1:0] hit_vec;
   logic             access_req;
   logic             refresh_req;

   // One comparator per bank against its fixed 16 KiB page.
   for (genvar gi = 0; gi < BANKS; gi++) begin : g_hit
      assign hit_vec[gi] = (ABANK == 2'(BANK_BASE + gi));
   end

   assign access_req  = !MREQ && RFSH && (!RD || !WR) && (|hit_vec);
   assign refresh_req = !MREQ && !RFSH;

   assign RAS   = ras_reg;
   assign CAS   = cas_reg;
   assign MUX   = mux_reg;
   assign WAIT  = wait_reg;
   assign RAMA7 = rama7_reg;

   // State register and registered outputs, with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_reg <= IDLE;
         timer_reg <= '0;
         sel_reg   <= '0;
         ras_reg   <= '1;
         cas_reg   <= '1;
         mux_reg   <= 1'b1;
         wait_reg  <= 1'b1;
         rama7_reg <= 1'b0;
         cnt_reg   <= '0;
         t_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         sel_reg   <= sel_next;
         ras_reg   <= ras_next;
         cas_reg   <= cas_next;
         mux_reg   <= mux_next;
         wait_reg  <= wait_next;
         rama7_reg <= rama7_next;
         cnt_reg   <= cnt_next;
         t_reg     <= t_next;
      end
   end

   // Next-state logic and strobe values. A strobe changes only where it is assigned here.
   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      sel_next   = sel_reg;
      ras_next   = ras_reg;
      cas_next   = cas_reg;
      mux_next   = mux_reg;
      cnt_next   = cnt_reg;
      t_next     = t_reg;
      // Hold the CPU only for a real access that arrives during precharge.
      // WAIT goes high again when IDLE accepts the access.
      wait_next  = !((state_reg == PRE) && access_req);
`ifdef MITEC2_CBR_REFRESH_EN
      rama7_next = A7;
`else
      rama7_next = RFSH ? A7 : t_reg;
`endif

      case (state_reg)
         IDLE: begin
            if (access_req) begin
               state_next = ROW;
               sel_next   = hit_vec;
               ras_next   = ~hit_vec;
               timer_next = 3'(T_RCD);
            end else if (refresh_req) begin
               state_next = REFR;
`ifdef MITEC2_CBR_REFRESH_EN
               cas_next   = '0;
`else
               ras_next   = '0;
`endif
            end
         end
         ROW: begin
            if (MREQ) begin
               state_next = PRE;
               timer_next = 3'(T_RP);
               ras_next   = '1;
               cas_next   = '1;
               mux_next   = 1'b1;
            end else if (timer_reg == 3'd1) begin
               state_next = COL;
               timer_next = 3'(T_MUX);
               mux_next   = 1'b0;
            end else begin
               timer_next = timer_reg - 3'd1;
            end
         end
         COL: begin
            if (MREQ) begin
               state_next = PRE;
               timer_next = 3'(T_RP);
               ras_next   = '1;
               cas_next   = '1;
               mux_next   = 1'b1;
            end else if (timer_reg == 3'd1) begin
               state_next = HOLD;
               cas_next   = ~sel_reg;
            end else begin
               timer_next = timer_reg - 3'd1;
            end
         end
         HOLD: begin
            if (MREQ) begin
               state_next = PRE;
               timer_next = 3'(T_RP);
               ras_next   = '1;
               cas_next   = '1;
               mux_next   = 1'b1;
            end
         end
         REFR: begin
            if (MREQ) begin
               state_next = PRE;
               timer_next = 3'(T_RP);
               ras_next   = '1;
               cas_next   = '1;
               mux_next   = 1'b1;
               cnt_next   = cnt_reg + 7'd1;
               if (cnt_reg == 7'd127)
                  t_next = ~t_reg;
            end else begin
               // For RAS-only refresh, this keeps RAS low.
               // For CBR refresh, this lowers RAS one clock after CAS.
               ras_next = '0;
            end
         end
         PRE: begin
            if (timer_reg == 3'd1)
               state_next = IDLE;
            else
               timer_next = timer_reg - 3'd1;
         end
         default: begin
            state_next = IDLE;
            ras_next   = '1;
            cas_next   = '1;
            mux_next   = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/mitec2_dram_seq.md
# mitec2_dram_seq

Clocked DRAM sequencer for the Z80 board: a parametrised successor to the asynchronous RAS/CAS/MUX glue. It decodes up to four 16 KiB DRAM banks from A15:A14 and generates registered RAS, CAS and MUX strobes with cycle-programmable row-to-column and precharge timing. It inserts Z80 WAIT states when an access arrives during precharge, and drives a refresh row bit (RAMA7) from an internal counter so 256-row parts get full refresh. It sits beside the memory/IO decode CPLD logic and replaces its delay-line DRAM timing.

## Interface
- BANKS, 2: number of DRAM banks, 1..4.
- BANK_BASE, 2: first 16 KiB page decoded as DRAM; BANK_BASE+BANKS <= 4.
- T_RCD, 1: clocks from RAS low to MUX low, 1..7.
- T_MUX, 1: clocks from MUX low to CAS low, 1..7.
- T_RP, 2: precharge clocks with all RAS high after any cycle, 1..7.

Ports:
- CLK  in  1  system clock (Z80 clock or 2x); all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- MREQ, RD, WR, RFSH  in  1 each  Z80 strobes, active low.
- ABANK  in  2  A15:A14.
- A7  in  1  CPU address bit 7.
- RAS  out  BANKS  per-bank row strobe, active low.
- CAS  out  BANKS  per-bank column strobe, active low.
- MUX  out  1  address mux select; high = row, low = column.
- RAMA7  out  1  DRAM address bit 7.
- WAIT  out  1  Z80 WAIT, active low.

## Operation
- Bank k (0..BANKS-1) hit: ABANK == BANK_BASE+k.
- Access request: MREQ=0, RFSH=1, (RD=0 or WR=0), bank hit.
- Refresh request: MREQ=0, RFSH=0.
- States: IDLE, ROW, COL, HOLD, REFR, PRE.
- IDLE:
  - Access -> ROW; RAS[k]=0, latch k.
  - Refresh -> REFR.
  - Access and refresh are mutually exclusive by RFSH.
- ROW: after T_RCD clocks -> COL, MUX=0.
- COL: after T_MUX clocks -> HOLD, CAS[k]=0.
- HOLD: when MREQ sampled 1 -> PRE; RAS, CAS and MUX all go high on that edge.
- Abort: MREQ sampled 1 in ROW or COL -> PRE immediately with all strobes high.
- REFR: all BANKS RAS low (RAS-only refresh); CAS and MUX stay high. When MREQ sampled 1 -> PRE, and the refresh counter increments.
- PRE: counts T_RP clocks, then -> IDLE. A request present on the final PRE clock is taken next cycle from IDLE.
- WAIT:
  - Driven 0 while in PRE and an access request is sampled.
  - Returns to 1 on the edge that enters ROW.
  - Never asserted for refresh; Z80 ignores WAIT in refresh.
- Refresh counter: 7-bit counter plus toggle bit T. The counter increments per completed refresh; T toggles when the counter wraps 127->0.
- RAMA7 = A7 when RFSH=1, T when RFSH=0. It is registered and follows the sampled inputs.
- Non-DRAM pages (no bank hit) are ignored; the state stays IDLE.

## Timing
- All outputs registered. Reset values: RAS all 1, CAS all 1, MUX 1, WAIT 1, RAMA7 0; counter 0, T 0, state IDLE.
- RESET low mid-cycle: all strobes inactive on the next edge, with no precharge wait.
- Access latency, request sampled at edge E:
  - RAS low at E.
  - MUX low at E+T_RCD.
  - CAS low at E+T_RCD+T_MUX.
- Deassert: MREQ high sampled at edge F -> strobes high at F. Next RAS possible at F+T_RP+1 at earliest.
- Minimum RAS-high time is T_RP+1 clocks in all cases, including abort and refresh.
- The latched bank index holds for the whole cycle; ABANK changes after E are ignored.
- Internal timer width is 3 bits, loaded on state entry.

## Configuration
- MITEC2_CBR_REFRESH_EN defined: refresh is CAS-before-RAS.
  - REFR entry drives all CAS=0.
  - All RAS=0 one clock later.
  - Both rise together when MREQ is sampled 1.
  - The counter/T logic is still present, but RAMA7 = A7 (refresh row comes from the DRAM's internal counter).
- Undefined: RAS-only refresh as described in Operation; CAS never asserted in refresh.

## Test plan
- Read, defaults: MREQ=RD=0, RFSH=1, ABANK=2 at edge 10 -> RAS=2'b10 at 10, MUX=0 at 11, CAS=2'b10 at 12. MREQ=1 at edge 14 -> all high at 14, idle by 16.
- Bank 3, T_RCD=2, T_MUX=3: write with ABANK=3 at edge 5 -> RAS=2'b01 at 5, MUX=0 at 7, CAS=2'b01 at 10. ABANK=0 -> no strobe activity.
- Back-to-back: second access sampled one clock after the first ends, T_RP=2 -> WAIT=0 for 2 clocks, RAS low 3 clocks after the previous RAS rise.
- Refresh: 128 RAS-only refreshes -> RAMA7 0 during the first 128, 1 during the next 128; CAS stays 3 throughout. Repeat with MITEC2_CBR_REFRESH_EN -> CAS=0 one clock before RAS=0.
- Abort and reset: MREQ returns 1 at ROW+1 -> RAS high that edge, no CAS. RESET=0 in HOLD -> all outputs at reset values next edge.
